otter_mem_arbiter: RTL and testbench

Shares one single-port unified memory between the pipelined OTTER's instruction-fetch port and its MEM-stage data port. It serialises requests, runs the memory request/acknowledge handshake, and returns read data with a one-cycle response pulse. Stall outputs feed the hazard unit. It sits inside OTTER_Wrapper, between the CPU core and the memory/MMIO block.

---
 rtl/otter_arb_pkg.sv | 25 ++
 rtl/otter_arb_starve_ctr.sv | 36 +++
 rtl/otter_mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_otter_mem_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_arb_pkg.sv
// Shared types for the OTTER memory arbiter: FSM states, grant encoding and byte-enable width.
package otter_arb_pkg;

    localparam int unsigned ARB_DATA_W = 32;
    localparam int unsigned ARB_BE_W   = ARB_DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP_I,
        RESP_D
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_I,
        GNT_D
    } arb_gnt_t;

    function automatic int unsigned be_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/otter_arb_starve_ctr.sv
// Saturating count of contested data grants; at_lim tells the arbiter a waiting fetch must win.
module otter_arb_starve_ctr #(
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic inc,
    input  logic clr,
    output logic at_lim
);

    localparam int unsigned CW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
    localparam logic [CW-1:0] LIM_V = CW'(STARVE_LIM);

    logic [CW-1:0] cnt_q, cnt_d;

    assign at_lim = (cnt_q == LIM_V);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_lim) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/otter_mem_arbiter.sv
// Shares one single-port memory between the OTTER fetch port and the MEM-stage data port,
// one transaction at a time, with one-cycle response pulses back to the requesters.
module otter_mem_arbiter
    import otter_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                I_REQ,
    input  logic [ADDR_W-1:0]   I_ADDR,
    output logic [DATA_W-1:0]   I_RDATA,
    output logic                I_VALID,
    output logic                I_STALL,
    input  logic                D_REQ,
    input  logic                D_WE,
    input  logic [DATA_W/8-1:0] D_BE,
    input  logic [ADDR_W-1:0]   D_ADDR,
    input  logic [DATA_W-1:0]   D_WDATA,
    output logic [DATA_W-1:0]   D_RDATA,
    output logic                D_DONE,
    output logic                D_STALL,
    output logic                M_REQ,
    output logic                M_WE,
    output logic [DATA_W/8-1:0] M_BE,
    output logic [ADDR_W-1:0]   M_ADDR,
    output logic [DATA_W-1:0]   M_WDATA,
    input  logic [DATA_W-1:0]   M_RDATA,
    input  logic                M_ACK
);

    localparam int unsigned BE_W = be_width(DATA_W);

    arb_state_t        state_q, state_d;
    arb_gnt_t          gnt;
    logic              starve;
    logic              ctr_inc, ctr_clr;

    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [BE_W-1:0]   m_be_q, m_be_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_valid_q, i_valid_d;
    logic              d_done_q, d_done_d;

    // Arbitration only happens in IDLE; data wins a tie unless the fetch has starved.
    always_comb begin
        gnt = GNT_NONE;
        if (state_q == IDLE) begin
            if (I_REQ && D_REQ) begin
                gnt = starve ? GNT_I : GNT_D;
            end else if (I_REQ) begin
                gnt = GNT_I;
            end else if (D_REQ) begin
                gnt = GNT_D;
            end
        end
    end

    assign ctr_inc = (gnt == GNT_D) && I_REQ;
    assign ctr_clr = (gnt == GNT_I);

    otter_arb_starve_ctr #(
        .STARVE_LIM (STARVE_LIM)
    ) u_starve (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .inc    (ctr_inc),
        .clr    (ctr_clr),
        .at_lim (starve)
    );

    always_comb begin
        state_d   = state_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_be_d    = m_be_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_valid_d = 1'b0;
        d_done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (gnt == GNT_I) begin
                    state_d  = BUSY_I;
                    m_req_d  = 1'b1;
                    m_we_d   = 1'b0;
                    m_be_d   = '1;
                    m_addr_d = I_ADDR;
                end else if (gnt == GNT_D) begin
                    state_d   = BUSY_D;
                    m_req_d   = 1'b1;
                    m_we_d    = D_WE;
                    m_be_d    = D_BE;
                    m_addr_d  = D_ADDR;
                    m_wdata_d = D_WDATA;
                end
            end
            BUSY_I: begin
                if (M_ACK) begin
                    state_d   = RESP_I;
                    m_req_d   = 1'b0;
                    i_rdata_d = M_RDATA;
                    i_valid_d = 1'b1;
                end
            end
            BUSY_D: begin
                if (M_ACK) begin
                    state_d  = RESP_D;
                    m_req_d  = 1'b0;
                    d_done_d = 1'b1;
                    if (!m_we_q) begin
                        d_rdata_d = M_RDATA;
                    end
                end
            end
            // Requests are ignored here so a requester dropping REQ after its pulse is served once.
            RESP_I, RESP_D: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_be_q    <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_valid_q <= 1'b0;
            d_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_be_q    <= m_be_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_valid_q <= i_valid_d;
            d_done_q  <= d_done_d;
        end
    end

    assign M_REQ   = m_req_q;
    assign M_WE    = m_we_q;
    assign M_BE    = m_be_q;
    assign M_ADDR  = m_addr_q;
    assign M_WDATA = m_wdata_q;
    assign I_RDATA = i_rdata_q;
    assign D_RDATA = d_rdata_q;
    assign I_VALID = i_valid_q;
    assign D_DONE  = d_done_q;
    assign I_STALL = I_REQ & ~i_valid_q;
    assign D_STALL = D_REQ & ~d_done_q;

    a_one_pulse: assert property (@(posedge CLK) disable iff (!RST_N) !(I_VALID && D_DONE));

    a_hold_mem: assert property (@(posedge CLK) disable iff (!RST_N)
        (M_REQ && !M_ACK) |=> (M_REQ && $stable(M_ADDR) && $stable(M_WE) && $stable(M_BE)
                               && $stable(M_WDATA)));

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Bench for otter_mem_arbiter: directed vector table, hand sequences and a randomized
// transaction-level reference model with a reactive memory responder.
module tb_otter_mem_arbiter;
    import otter_arb_pkg::*;

    localparam int unsigned LIM = 4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        I_REQ, D_REQ, D_WE, M_ACK;
    logic [31:0] I_ADDR, D_ADDR, D_WDATA, M_RDATA;
    logic [3:0]  D_BE;
    logic [31:0] I_RDATA, D_RDATA, M_ADDR, M_WDATA;
    logic        I_VALID, I_STALL, D_DONE, D_STALL, M_REQ, M_WE;
    logic [3:0]  M_BE;

    otter_mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_LIM (LIM)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .I_REQ   (I_REQ),
        .I_ADDR  (I_ADDR),
        .I_RDATA (I_RDATA),
        .I_VALID (I_VALID),
        .I_STALL (I_STALL),
        .D_REQ   (D_REQ),
        .D_WE    (D_WE),
        .D_BE    (D_BE),
        .D_ADDR  (D_ADDR),
        .D_WDATA (D_WDATA),
        .D_RDATA (D_RDATA),
        .D_DONE  (D_DONE),
        .D_STALL (D_STALL),
        .M_REQ   (M_REQ),
        .M_WE    (M_WE),
        .M_BE    (M_BE),
        .M_ADDR  (M_ADDR),
        .M_WDATA (M_WDATA),
        .M_RDATA (M_RDATA),
        .M_ACK   (M_ACK)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: acks after mem_wait extra cycles of M_REQ, data is a hash of the address.
    int          mem_wait = 0;
    bit          mem_fix  = 0;
    logic [31:0] mem_fix_data = 32'h0;
    int          req_cnt  = 0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    initial begin
        M_ACK   = 1'b0;
        M_RDATA = 32'h0;
        forever begin
            @(negedge CLK);
            if (M_REQ === 1'b1) begin
                M_ACK = (req_cnt == mem_wait);
                req_cnt++;
            end else begin
                M_ACK   = 1'b0;
                req_cnt = 0;
            end
            M_RDATA = mem_fix ? mem_fix_data : mem_f(M_ADDR);
        end
    end

    task automatic clear_inputs();
        I_REQ = 1'b0; I_ADDR = 32'h0;
        D_REQ = 1'b0; D_WE = 1'b0; D_BE = 4'h0; D_ADDR = 32'h0; D_WDATA = 32'h0;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        clear_inputs();
        mem_wait = 0;
        mem_fix  = 0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge CLK);
        check1({tag, ".idle_m_req"}, M_REQ, 1'b0);
        check1({tag, ".idle_pulse"}, I_VALID | D_DONE, 1'b0);
    endtask

    // Called at a negedge in an IDLE cycle with requests already driven.
    task automatic expect_txn(input string tag, input arb_gnt_t who, input int w,
                              input logic [31:0] maddr, input logic mwe, input logic [3:0] mbe,
                              input logic [31:0] mwdata, input logic [31:0] ird,
                              input logic [31:0] drd);
        for (int k = 0; k <= w; k++) begin
            @(negedge CLK);
            check1({tag, ".m_req"}, M_REQ, 1'b1);
            check32({tag, ".m_addr"}, M_ADDR, maddr);
            check1({tag, ".m_we"}, M_WE, mwe);
            check32({tag, ".m_be"}, 32'(M_BE), 32'(mbe));
            if (who == GNT_D) check32({tag, ".m_wdata"}, M_WDATA, mwdata);
            check1({tag, ".early_pulse"}, I_VALID | D_DONE, 1'b0);
            check1({tag, ".i_stall"}, I_STALL, I_REQ);
            check1({tag, ".d_stall"}, D_STALL, D_REQ);
        end
        @(negedge CLK);
        check1({tag, ".m_req_drop"}, M_REQ, 1'b0);
        check1({tag, ".i_valid"}, I_VALID, who == GNT_I);
        check1({tag, ".d_done"}, D_DONE, who == GNT_D);
        check32({tag, ".i_rdata"}, I_RDATA, ird);
        check32({tag, ".d_rdata"}, D_RDATA, drd);
        check1({tag, ".i_stall_pulse"}, I_STALL, I_REQ && (who != GNT_I));
        check1({tag, ".d_stall_pulse"}, D_STALL, D_REQ && (who != GNT_D));
    endtask

    typedef struct {
        logic        ireq;
        logic        dreq;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [31:0] mdata;
        int          w;
        arb_gnt_t    who;
        logic [31:0] maddr;
        logic        mwe;
        logic [3:0]  mbe;
        logic [31:0] ird;
        logic [31:0] drd;
    } vec_t;

    localparam int NV = 7;
    vec_t     vt[NV];
    arb_gnt_t order[6] = '{GNT_D, GNT_D, GNT_D, GNT_D, GNT_I, GNT_D};

    // Reference model: grants at idle edges from the spec's priority rules, timing by arithmetic.
    task automatic random_phase(input int n_edges);
        int          e = 0, g = 0, w = 0, next_arb = 0, cnt = 0;
        bit          busy = 0, ion = 0, don = 0, exp_mreq, exp_iv, exp_dd;
        arb_gnt_t    who = GNT_NONE;
        logic [31:0] ia = 0, da = 0, dw = 0, ga = 0, gw = 0, exp_ir = 0, exp_dr = 0;
        logic        dwe = 0, gwe = 0;
        logic [3:0]  dbe = 0, gbe = 0;
        mem_fix = 0;
        for (int it = 0; it < n_edges; it++) begin
            if (!ion && $urandom_range(0, 3) == 0) begin
                ion = 1;
                ia  = $urandom & 32'hFFFF_FFFC;
            end
            if (!don && $urandom_range(0, 1) == 0) begin
                don = 1;
                da  = $urandom & 32'hFFFF_FFFC;
                dw  = $urandom;
                dwe = 1'($urandom_range(0, 1));
                dbe = 4'($urandom_range(1, 15));
            end
            I_REQ = ion; I_ADDR = ia;
            D_REQ = don; D_ADDR = da; D_WDATA = dw; D_WE = dwe; D_BE = dbe;
            if (!busy && e >= next_arb && (ion || don)) begin
                if (ion && don) who = (cnt == LIM) ? GNT_I : GNT_D;
                else            who = ion ? GNT_I : GNT_D;
                if (who == GNT_D && ion) cnt = (cnt < LIM) ? cnt + 1 : LIM;
                if (who == GNT_I) cnt = 0;
                busy = 1;
                g    = e;
                w    = $urandom_range(0, 3);
                mem_wait = w;
                if (who == GNT_I) begin
                    ga = ia; gwe = 0; gbe = 4'hF;
                end else begin
                    ga = da; gwe = dwe; gbe = dbe; gw = dw;
                end
            end
            @(negedge CLK);
            exp_mreq = busy && e >= g && e <= g + w;
            exp_iv   = busy && who == GNT_I && e == g + w + 1;
            exp_dd   = busy && who == GNT_D && e == g + w + 1;
            if (exp_iv) exp_ir = mem_f(ga);
            if (exp_dd && !gwe) exp_dr = mem_f(ga);
            check1("rnd.m_req", M_REQ, exp_mreq);
            check1("rnd.i_valid", I_VALID, exp_iv);
            check1("rnd.d_done", D_DONE, exp_dd);
            check32("rnd.i_rdata", I_RDATA, exp_ir);
            check32("rnd.d_rdata", D_RDATA, exp_dr);
            check1("rnd.i_stall", I_STALL, ion && !exp_iv);
            check1("rnd.d_stall", D_STALL, don && !exp_dd);
            if (exp_mreq) begin
                check32("rnd.m_addr", M_ADDR, ga);
                check1("rnd.m_we", M_WE, gwe);
                check32("rnd.m_be", 32'(M_BE), 32'(gbe));
                if (who == GNT_D) check32("rnd.m_wdata", M_WDATA, gw);
            end
            if (exp_iv) ion = 0;
            if (exp_dd) don = 0;
            if (exp_iv || exp_dd) begin
                busy     = 0;
                next_arb = e + 2;
            end
            e++;
        end
        clear_inputs();
        repeat (6) @(negedge CLK);
    endtask

    initial begin
        logic [31:0] ird, drd;
        arb_gnt_t    who;

        vt[0] = '{ireq: 1, dreq: 0, dwe: 0, dbe: 4'h0, iaddr: 32'h0000_0100, daddr: 32'h0,
                  dwdata: 32'h0, mdata: 32'h0000_0013, w: 0, who: GNT_I, maddr: 32'h0000_0100,
                  mwe: 0, mbe: 4'hF, ird: 32'h0000_0013, drd: 32'h0};
        vt[1] = '{ireq: 0, dreq: 1, dwe: 0, dbe: 4'hF, iaddr: 32'h0, daddr: 32'h1100_0000,
                  dwdata: 32'h0, mdata: 32'hDEAD_BEEF, w: 1, who: GNT_D, maddr: 32'h1100_0000,
                  mwe: 0, mbe: 4'hF, ird: 32'h0000_0013, drd: 32'hDEAD_BEEF};
        vt[2] = '{ireq: 0, dreq: 1, dwe: 1, dbe: 4'b0010, iaddr: 32'h0, daddr: 32'h1100_0004,
                  dwdata: 32'h0000_AB00, mdata: 32'h5555_5555, w: 0, who: GNT_D,
                  maddr: 32'h1100_0004, mwe: 1, mbe: 4'b0010, ird: 32'h0000_0013,
                  drd: 32'hDEAD_BEEF};
        vt[3] = '{ireq: 1, dreq: 1, dwe: 0, dbe: 4'hF, iaddr: 32'h0000_0200,
                  daddr: 32'h1100_0008, dwdata: 32'h0, mdata: 32'h1234_5678, w: 2, who: GNT_D,
                  maddr: 32'h1100_0008, mwe: 0, mbe: 4'hF, ird: 32'h0000_0013,
                  drd: 32'h1234_5678};
        vt[4] = '{ireq: 1, dreq: 1, dwe: 1, dbe: 4'hF, iaddr: 32'h0000_0204,
                  daddr: 32'h0000_0300, dwdata: 32'hCAFE_F00D, mdata: 32'h0BAD_0BAD, w: 0,
                  who: GNT_D, maddr: 32'h0000_0300, mwe: 1, mbe: 4'hF, ird: 32'h0000_0013,
                  drd: 32'h1234_5678};
        vt[5] = '{ireq: 1, dreq: 0, dwe: 0, dbe: 4'h0, iaddr: 32'h0000_0208, daddr: 32'h0,
                  dwdata: 32'h0, mdata: 32'h0000_0073, w: 3, who: GNT_I, maddr: 32'h0000_0208,
                  mwe: 0, mbe: 4'hF, ird: 32'h0000_0073, drd: 32'h1234_5678};
        vt[6] = '{ireq: 1, dreq: 1, dwe: 0, dbe: 4'b1100, iaddr: 32'h0000_020C,
                  daddr: 32'h0000_0400, dwdata: 32'h0, mdata: 32'h0000_7777, w: 0, who: GNT_D,
                  maddr: 32'h0000_0400, mwe: 0, mbe: 4'b1100, ird: 32'h0000_0073,
                  drd: 32'h0000_7777};

        RST_N = 1'b0;
        clear_inputs();
        repeat (2) @(negedge CLK);
        check1("reset.m_req", M_REQ, 1'b0);
        check1("reset.m_we", M_WE, 1'b0);
        check32("reset.m_be", 32'(M_BE), 32'h0);
        check32("reset.m_addr", M_ADDR, 32'h0);
        check32("reset.m_wdata", M_WDATA, 32'h0);
        check32("reset.i_rdata", I_RDATA, 32'h0);
        check32("reset.d_rdata", D_RDATA, 32'h0);
        check1("reset.pulses", I_VALID | D_DONE, 1'b0);
        RST_N = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < NV; i++) begin
            mem_fix = 1; mem_fix_data = vt[i].mdata; mem_wait = vt[i].w;
            I_REQ = vt[i].ireq; I_ADDR = vt[i].iaddr;
            D_REQ = vt[i].dreq; D_WE = vt[i].dwe; D_BE = vt[i].dbe;
            D_ADDR = vt[i].daddr; D_WDATA = vt[i].dwdata;
            expect_txn($sformatf("vec%0d", i), vt[i].who, vt[i].w, vt[i].maddr, vt[i].mwe,
                       vt[i].mbe, vt[i].dwdata, vt[i].ird, vt[i].drd);
            I_REQ = 1'b0; D_REQ = 1'b0;
            idle_cycle($sformatf("vec%0d", i));
        end

        // Contention with a 2-wait memory: data first, then the fetch that stayed pending.
        mem_fix = 0; mem_wait = 2;
        I_REQ = 1; I_ADDR = 32'h0000_0500;
        D_REQ = 1; D_WE = 0; D_BE = 4'hF; D_ADDR = 32'h1100_0000; D_WDATA = 32'h0;
        drd = mem_f(32'h1100_0000);
        expect_txn("p2.d", GNT_D, 2, 32'h1100_0000, 1'b0, 4'hF, 32'h0, vt[NV-1].ird, drd);
        D_REQ = 0;
        idle_cycle("p2");
        expect_txn("p2.i", GNT_I, 2, 32'h0000_0500, 1'b0, 4'hF, 32'h0, mem_f(32'h500), drd);
        I_REQ = 0;
        idle_cycle("p2.end");

        // Starvation: fetch held against back-to-back data requests.
        do_reset();
        I_REQ = 1; I_ADDR = 32'h0000_0600;
        D_REQ = 1; D_WE = 0; D_BE = 4'hF; D_ADDR = 32'h1100_0010; D_WDATA = 32'h0;
        ird = 32'h0; drd = 32'h0;
        for (int k = 0; k < 6; k++) begin
            who = order[k];
            if (who == GNT_I) ird = mem_f(I_ADDR);
            else              drd = mem_f(D_ADDR);
            expect_txn($sformatf("starve%0d", k), who, 0, (who == GNT_I) ? I_ADDR : D_ADDR,
                       1'b0, 4'hF, D_WDATA, ird, drd);
            if (who == GNT_I) begin
                check32("starve.cnt_after_i", 32'(dut.u_starve.cnt_q), 32'h0);
                I_ADDR = I_ADDR + 32'h4;
            end else begin
                D_ADDR = D_ADDR + 32'h4;
            end
            if (k == 5) begin
                I_REQ = 0; D_REQ = 0;
            end
            idle_cycle($sformatf("starve%0d", k));
        end

        // Reset in the middle of a stalled data access.
        do_reset();
        D_REQ = 1; D_WE = 0; D_BE = 4'hF; D_ADDR = 32'h1100_0040; D_WDATA = 32'h0;
        expect_txn("rst.pre", GNT_D, 0, 32'h1100_0040, 1'b0, 4'hF, 32'h0, 32'h0,
                   mem_f(32'h1100_0040));
        D_ADDR = 32'h1100_0044; D_WDATA = 32'h0000_5A5A; D_WE = 1; mem_wait = 1000;
        idle_cycle("rst.pre");
        repeat (2) begin
            @(negedge CLK);
            check1("rst.busy_m_req", M_REQ, 1'b1);
        end
        #2 RST_N = 1'b0;
        #1;
        check1("rst.m_req", M_REQ, 1'b0);
        check1("rst.m_we", M_WE, 1'b0);
        check32("rst.m_be", 32'(M_BE), 32'h0);
        check32("rst.m_addr", M_ADDR, 32'h0);
        check32("rst.m_wdata", M_WDATA, 32'h0);
        check32("rst.i_rdata", I_RDATA, 32'h0);
        check32("rst.d_rdata", D_RDATA, 32'h0);
        check1("rst.pulses", I_VALID | D_DONE, 1'b0);
        @(negedge CLK);
        D_REQ = 0; mem_wait = 0;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check1("rst.no_done", D_DONE, 1'b0);
            check1("rst.no_m_req", M_REQ, 1'b0);
        end
        I_REQ = 1; I_ADDR = 32'h0000_0700;
        expect_txn("rst.post", GNT_I, 0, 32'h0000_0700, 1'b0, 4'hF, 32'h0, mem_f(32'h700),
                   32'h0);
        I_REQ = 0;
        idle_cycle("rst.post");

        // Data requester holds REQ across the pulse-ending edge, then drops it.
        D_REQ = 1; D_WE = 0; D_BE = 4'hF; D_ADDR = 32'h1100_0030;
        expect_txn("hold", GNT_D, 0, 32'h1100_0030, 1'b0, 4'hF, D_WDATA, mem_f(32'h700),
                   mem_f(32'h1100_0030));
        @(posedge CLK);
        #1 D_REQ = 0;
        repeat (6) begin
            @(negedge CLK);
            check1("hold.no_second_m_req", M_REQ, 1'b0);
            check1("hold.no_second_done", D_DONE, 1'b0);
        end

        do_reset();
        random_phase(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
